quant_row_sequencer: RTL and testbench
======================================

# quant_row_sequencer

Row-level controller for the JPEG quantization stage. Accepts 8-coefficient rows of a DCT block over a valid/ready handshake and tracks the row index 0..7 within the block. Applies the matching quantization-table row, saturates the results, and presents one registered 72-bit output row with block framing flags. It sits between the DCT row output and the zig-zag/entropy stage and replaces free-running row counting with handshake-driven sequencing.

## Interface
Parameters:
- COEF_W, 8, input coefficient width (signed)
- OUT_W, 9, output coefficient width (signed)
- BLK_CNT_W, 16, completed-block counter width

Ports:
- clk  in  1  clock, single domain
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of the current block
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid && in_ready
- in_data  in  64  8 signed coefficients; element 0 = [63:56], element 7 = [7:0]
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts output row
- out_data  out  72  8 signed 9-bit results; element 0 = [71:63], element 7 = [8:0]
- out_sof  out  1  output row is row 0 of a block
- out_eof  out  1  output row is row 7 of a block
- busy  out  1  a block is partially accepted (row_idx != 0)
- blk_count  out  BLK_CNT_W  blocks whose eof row was handed off; wraps

## Operation
- State: row_idx (3 bits) plus a 2-state FSM, IDLE (row_idx==0) and IN_BLOCK (row_idx 1..7). busy=1 in IN_BLOCK.
- in_ready = !flush && (!out_valid || out_ready). The block has one output register and no skid buffer.
- On accept:
  - element i → out_data element i = sat9(in_data[i] × QTABLE[row_idx][i])
  - out_sof = (row_idx==0), out_eof = (row_idx==7)
  - out_valid ← 1
  - row_idx ← row_idx+1, wrapping 7→0 (IN_BLOCK→IDLE)
- Arithmetic:
  - signed 8-bit × unsigned 7-bit → 15-bit signed product
  - sat9 clamps to [-256, 255]; no rounding and no division (the table holds multipliers)
- Output hold: while out_valid && !out_ready, out_data, out_sof and out_eof stay stable.
- Output handoff: out_valid && out_ready without a new accept → out_valid ← 0. A handoff and an accept in the same cycle → new row loaded, out_valid stays 1.
- blk_count increments on out_valid && out_ready && out_eof.
- flush:
  - row_idx ← 0, out_valid ← 0, FSM → IDLE
  - blk_count unchanged
  - in_ready is forced 0 that cycle
  - flush wins over any simultaneous accept or handoff; a handoff coinciding with flush does not count.
- Protocol rule: in_data must be held stable while in_valid && !in_ready. Violations are not detected.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof=0, out_eof=0, busy=0, blk_count=0, row_idx=0. in_ready=1 after reset deasserts.
- Latency: one cycle from accept to out_valid.
- Throughput: one row per cycle with out_ready held high; 8 cycles per block.
- Reset mid-block discards the partial block and the pending output row. The next accepted row is row 0.

## Structure
- Package quant_pkg holds:
  - COEF_W, OUT_W and the row/element index width
  - QTABLE[8][8], 7-bit hex, rows 0..7:
    - row 0: 20 0B 0C 08 05 03 02 02
    - row 1: 0A 0A 09 06 04 02 02 02
    - row 2: 09 09 08 05 03 02 01 02
    - row 3: 09 07 05 04 02 01 01 02
    - row 4: 07 05 03 02 01 01 01 01
    - row 5: 05 03 02 02 01 01 01 01
    - row 6: 02 02 01 01 01 01 01 01
    - row 7: all 01
  - function sat9
- Sub-module quant_row_mult: combinational, inputs row_idx and in_data, output 72-bit saturated products. The sequencer owns all registers, the FSM and the handshake.

## Test plan
- Reset, then 8 rows, each in_data=0x0101010101010101, out_ready=1:
  - row 0 out_data elements = 020,00B,00C,008,005,003,002,002 with sof=1
  - row 7 all 001 with eof=1
  - blk_count=1, busy=0 afterwards
- Saturation on row 0, element 0 = 0x7F then 0x80 (other elements 0) → element 0 = 0x0FF then 0x100. The second value arrives on row 1, where 0x80×0x0A = −1280 also clamps to 0x100.
- Backpressure: out_ready=0 for 3 cycles after the first output → in_ready=0, out_data stable, no row lost. On release, rows continue at one per cycle.
- Flush after 3 rows accepted (busy=1) → out_valid=0, busy=0, blk_count unchanged. The next accepted row gets sof=1 and the row-0 table.
- Asynchronous reset pulse mid-row-5, between clock edges → outputs at reset values immediately. The following block starts at row 0.
- Simultaneous handoff and accept for 16 cycles with in_valid=out_ready=1 → out_valid continuously 1, blk_count=2, sof/eof at cycles 1, 8, 9, 16.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared definitions for the JPEG quantization row sequencer.
// Holds coefficient/result widths, the row-index width, the FSM state type,
// the 8x8 quantization multiplier table and the output saturation helper.
package quant_pkg;

  localparam int COEF_W = 8;               // signed input coefficient width
  localparam int OUT_W  = 9;               // signed saturated result width
  localparam int Q_W    = 7;               // unsigned table entry width
  localparam int NUM_EL = 8;               // coefficients per row / rows per block
  localparam int IDX_W  = 3;               // row / element index width
  localparam int PROD_W = COEF_W + Q_W;    // signed product width

  typedef enum logic {
    S_IDLE     = 1'b0,                     // row_idx == 0
    S_IN_BLOCK = 1'b1                      // row_idx in 1..7
  } state_e;

  // Table holds multipliers (not divisors); row r applies to row r of a block.
  localparam logic [Q_W-1:0] QTABLE [NUM_EL][NUM_EL] = '{
    '{7'h20, 7'h0B, 7'h0C, 7'h08, 7'h05, 7'h03, 7'h02, 7'h02},
    '{7'h0A, 7'h0A, 7'h09, 7'h06, 7'h04, 7'h02, 7'h02, 7'h02},
    '{7'h09, 7'h09, 7'h08, 7'h05, 7'h03, 7'h02, 7'h01, 7'h02},
    '{7'h09, 7'h07, 7'h05, 7'h04, 7'h02, 7'h01, 7'h01, 7'h02},
    '{7'h07, 7'h05, 7'h03, 7'h02, 7'h01, 7'h01, 7'h01, 7'h01},
    '{7'h05, 7'h03, 7'h02, 7'h02, 7'h01, 7'h01, 7'h01, 7'h01},
    '{7'h02, 7'h02, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01},
    '{7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01}
  };

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(255);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-256);

  // Clamp a signed product into the 9-bit signed output range.
  function automatic logic [OUT_W-1:0] sat9(input logic signed [PROD_W-1:0] p);
    if (p > SAT_MAX)      return 9'h0FF;
    else if (p < SAT_MIN) return 9'h100;
    else                  return p[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/quant_row_mult.sv
// Combinational row quantizer: multiplies each of the 8 signed coefficients
// by the table entry for (row_idx, element) and saturates to 9 bits.
// Ports:
//   row_idx_i  row index within the block, selects the table row
//   in_data_i  8 signed coefficients, element 0 in the MSBs
//   prod_o     8 saturated signed results, element 0 in the MSBs
module quant_row_mult
  import quant_pkg::*;
(
  input  logic [IDX_W-1:0]         row_idx_i,
  input  logic [NUM_EL*COEF_W-1:0] in_data_i,
  output logic [NUM_EL*OUT_W-1:0]  prod_o
);

  for (genvar i = 0; i < NUM_EL; i++) begin : g_el
    logic signed [COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod;
    assign coef = in_data_i[(NUM_EL-1-i)*COEF_W +: COEF_W];
    // Zero-extend the unsigned table entry so the multiply stays signed.
    assign prod = PROD_W'(coef) * PROD_W'($signed({1'b0, QTABLE[row_idx_i][i]}));
    assign prod_o[(NUM_EL-1-i)*OUT_W +: OUT_W] = sat9(prod);
  end

endmodule

// File: rtl/quant_row_sequencer.sv
// Row-level controller for the JPEG quantization stage.
// Accepts 8-coefficient rows over valid/ready, tracks the row index within
// the 8-row block, quantizes via quant_row_mult and holds one registered
// output row with sof/eof framing. Single output register, no skid buffer.
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   flush                   synchronous abort of the current block
//   in_valid/in_ready/in_data    input row handshake, 8 x signed COEF_W
//   out_valid/out_ready/out_data output row handshake, 8 x signed OUT_W
//   out_sof/out_eof         output row is row 0 / row 7 of a block
//   busy                    block partially accepted (row_idx != 0)
//   blk_count               blocks whose eof row was handed off (wraps)
module quant_row_sequencer #(
  parameter int COEF_W    = 8,
  parameter int OUT_W     = 9,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*COEF_W-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   out_data,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_count
);
  import quant_pkg::*;

  state_e                 state_q;
  logic [IDX_W-1:0]       row_idx_q, row_idx_d;
  logic                   out_valid_q, sof_q, eof_q;
  logic [8*OUT_W-1:0]     out_data_q, prod;
  logic [BLK_CNT_W-1:0]   blk_count_q;
  logic                   accept, handoff;

  quant_row_mult u_mult (
    .row_idx_i (row_idx_q),
    .in_data_i (in_data),
    .prod_o    (prod)
  );

  // The output register can take a new row if empty or draining this cycle.
  assign in_ready  = !flush && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid_q && out_ready;
  assign row_idx_d = row_idx_q + 1'b1;   // 3-bit wrap 7 -> 0

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      blk_count_q <= '0;
    end else if (flush) begin
      // Flush dominates: drop the pending row without counting its handoff.
      state_q     <= S_IDLE;
      row_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (handoff && eof_q) blk_count_q <= blk_count_q + 1'b1;
      if (accept) begin
        out_data_q  <= prod;
        sof_q       <= (row_idx_q == 3'd0);
        eof_q       <= (row_idx_q == 3'd7);
        out_valid_q <= 1'b1;
        row_idx_q   <= row_idx_d;
        state_q     <= (row_idx_d == 3'd0) ? S_IDLE : S_IN_BLOCK;
      end else if (handoff) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign busy      = (state_q == S_IN_BLOCK);
  assign blk_count = blk_count_q;

endmodule

// File: tb/tb_quant_row_sequencer.sv
module tb_quant_row_sequencer;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_sof, out_eof, busy;
  logic [63:0] in_data;
  logic [71:0] out_data;
  logic [15:0] blk_count;

  int checks = 0;
  int failures = 0;

  quant_row_sequencer #(.COEF_W(8), .OUT_W(9), .BLK_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  // Reference model: block position counted in accepted rows, output row
  // computed with integer multiply and clamp.
  int qt [8][8] = '{
    '{32, 11, 12, 8, 5, 3, 2, 2},
    '{10, 10,  9, 6, 4, 2, 2, 2},
    '{ 9,  9,  8, 5, 3, 2, 1, 2},
    '{ 9,  7,  5, 4, 2, 1, 1, 2},
    '{ 7,  5,  3, 2, 1, 1, 1, 1},
    '{ 5,  3,  2, 2, 1, 1, 1, 1},
    '{ 2,  2,  1, 1, 1, 1, 1, 1},
    '{ 1,  1,  1, 1, 1, 1, 1, 1}
  };

  int          m_rows;     // rows accepted in current block
  bit          m_valid, m_sof, m_eof;
  logic [71:0] m_data;
  logic [15:0] m_blk;
  bit          exp_rdy, obs_rdy;

  function automatic logic [71:0] ref_row(input logic [63:0] d, input int r);
    logic [71:0] res;
    logic [7:0]  b;
    int          c, p;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      b = d[63-8*i -: 8];
      c = $signed(b);
      p = c * qt[r][i];
      if (p > 255)  p = 255;
      if (p < -256) p = -256;
      res[71-9*i -: 9] = p[8:0];
    end
    return res;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [92:0] obs_vec();
    return {obs_rdy, out_valid, out_sof, out_eof, busy, blk_count, out_data};
  endfunction

  function automatic logic [92:0] exp_vec();
    return {exp_rdy, m_valid, m_sof, m_eof, (m_rows != 0), m_blk, m_data};
  endfunction

  task automatic model_reset();
    m_rows = 0; m_valid = 0; m_sof = 0; m_eof = 0; m_data = '0; m_blk = '0;
    exp_rdy = 1;
  endtask

  // One clock: drive at negedge, sample in_ready before the edge, advance
  // the model at the edge, return at the following negedge.
  task automatic cycle(input bit v, input logic [63:0] d, input bit ordy, input bit fl);
    bit acc, ho;
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    #1;
    obs_rdy = in_ready;
    exp_rdy = !fl && (!m_valid || ordy);
    acc = v && exp_rdy;
    ho  = m_valid && ordy;
    @(posedge clk);
    if (fl) begin
      m_rows = 0; m_valid = 0;
    end else begin
      if (ho && m_eof) m_blk++;
      if (acc) begin
        m_data  = ref_row(d, m_rows);
        m_sof   = (m_rows == 0);
        m_eof   = (m_rows == 7);
        m_valid = 1;
        m_rows  = (m_rows + 1) % 8;
      end else if (ho) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, out_sof, out_eof, busy, blk_count, out_data} !== 93'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%b sof=%b eof=%b busy=%b blk=%0d data=%h, want all zero",
               out_valid, out_sof, out_eof, busy, blk_count, out_data);
    end
    reset = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [71:0] row0, row7;
    row0 = {9'h020, 9'h00B, 9'h00C, 9'h008, 9'h005, 9'h003, 9'h002, 9'h002};
    row7 = {8{9'h001}};
    for (int r = 0; r < 8; r++) begin
      cycle(1, 64'h0101010101010101, 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL basic row%0d: got %h want %h", r, obs_vec(), exp_vec());
      end
      if (r == 0) begin
        checks++;
        if (out_data !== row0 || out_sof !== 1'b1) begin
          failures++;
          $display("FAIL basic_row0_const: got data=%h sof=%b want data=%h sof=1", out_data, out_sof, row0);
        end
      end
      if (r == 7) begin
        checks++;
        if (out_data !== row7 || out_eof !== 1'b1) begin
          failures++;
          $display("FAIL basic_row7_const: got data=%h eof=%b want data=%h eof=1", out_data, out_eof, row7);
        end
      end
    end
    cycle(0, '0, 1, 0);
    checks++;
    if (blk_count !== 16'd1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: got blk=%0d busy=%b v=%b want blk=1 busy=0 v=0", blk_count, busy, out_valid);
    end
  endtask

  task automatic test_saturation();
    cycle(1, {8'h7F, 56'h0}, 1, 0);
    checks++;
    if (out_data[71:63] !== 9'h0FF || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL sat_pos: got el0=%h vec=%h want el0=0ff vec=%h", out_data[71:63], obs_vec(), exp_vec());
    end
    cycle(1, {8'h80, 56'h0}, 1, 0);
    checks++;
    if (out_data[71:63] !== 9'h100 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL sat_neg: got el0=%h vec=%h want el0=100 vec=%h", out_data[71:63], obs_vec(), exp_vec());
    end
    for (int r = 2; r < 9; r++) begin
      cycle(r < 8, rnd64(), 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL sat_rest row%0d: got %h want %h", r, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [71:0] held;
    logic [63:0] d;
    cycle(1, rnd64(), 1, 0);
    held = out_data;
    d = rnd64();
    for (int k = 0; k < 3; k++) begin
      cycle(1, d, 0, 0);
      checks++;
      if (obs_rdy !== 1'b0 || out_data !== held || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bp_hold%0d: got rdy=%b data=%h vec=%h want rdy=0 data=%h vec=%h",
                 k, obs_rdy, out_data, obs_vec(), held, exp_vec());
      end
    end
    cycle(1, d, 1, 0);
    for (int r = 2; r < 9; r++) begin
      checks++;
      if (obs_vec() !== exp_vec() || obs_rdy !== 1'b1) begin
        failures++;
        $display("FAIL bp_release row%0d: got %h want %h", r - 1, obs_vec(), exp_vec());
      end
      cycle(r < 8, rnd64(), 1, 0);
    end
    checks++;
    if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_flush();
    logic [15:0] blk0;
    logic [63:0] d;
    blk0 = m_blk;
    for (int r = 0; r < 3; r++) cycle(1, rnd64(), 1, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre_busy: got %b want 1", busy);
    end
    cycle(1, rnd64(), 1, 1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || blk_count !== blk0 || obs_rdy !== 1'b0) begin
      failures++;
      $display("FAIL flush: got v=%b busy=%b blk=%0d rdy=%b want v=0 busy=0 blk=%0d rdy=0",
               out_valid, busy, blk_count, obs_rdy, blk0);
    end
    d = rnd64();
    cycle(1, d, 1, 0);
    checks++;
    if (out_sof !== 1'b1 || out_data !== ref_row(d, 0) || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL flush_restart: got sof=%b data=%h want sof=1 data=%h", out_sof, out_data, ref_row(d, 0));
    end
    for (int r = 1; r < 9; r++) cycle(r < 8, rnd64(), 1, 0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL flush_block_end: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] d;
    for (int r = 0; r < 5; r++) cycle(1, rnd64(), 1, 0);
    in_valid = 1; in_data = rnd64(); out_ready = 1; flush = 0;
    #2 reset = 1;
    #1;
    checks++;
    if ({out_valid, out_sof, out_eof, busy, blk_count, out_data} !== 93'd0) begin
      failures++;
      $display("FAIL async_reset: got v=%b sof=%b eof=%b busy=%b blk=%0d data=%h, want all zero",
               out_valid, out_sof, out_eof, busy, blk_count, out_data);
    end
    in_valid = 0;
    #1 reset = 0;
    model_reset();
    @(negedge clk);
    d = rnd64();
    cycle(1, d, 1, 0);
    checks++;
    if (out_sof !== 1'b1 || out_data !== ref_row(d, 0) || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL async_restart: got sof=%b data=%h want sof=1 data=%h", out_sof, out_data, ref_row(d, 0));
    end
    for (int r = 1; r < 9; r++) cycle(r < 8, rnd64(), 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] blk0;
    blk0 = m_blk;
    for (int i = 0; i < 16; i++) begin
      cycle(1, rnd64(), 1, 0);
      checks++;
      if (obs_vec() !== exp_vec() || out_valid !== 1'b1 ||
          out_sof !== (i % 8 == 0) || out_eof !== (i % 8 == 7)) begin
        failures++;
        $display("FAIL b2b cyc%0d: got v=%b sof=%b eof=%b vec=%h want v=1 sof=%b eof=%b vec=%h",
                 i + 1, out_valid, out_sof, out_eof, obs_vec(), (i % 8 == 0), (i % 8 == 7), exp_vec());
      end
    end
    cycle(0, '0, 1, 0);
    checks++;
    if (blk_count !== blk0 + 16'd2) begin
      failures++;
      $display("FAIL b2b_blk: got %0d want %0d", blk_count, blk0 + 16'd2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd64(), $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
